ppu_linemult_seq: RTL
=====================

PPU_LINEMULT_SEQ -- requirements
Module: ppu_linemult_seq

Interface
REQ-001 The block SHALL have parameter MUTE_CYCLES, default 4, meaning the cycles spent in MUTE before the clock switch (valid range 1..255).
REQ-002 The block SHALL have parameter CLKSW_CYCLES, default 16, meaning the cycles the line multiplier is held in reset after the switch (valid range 1..255).
REQ-003 The block SHALL have parameter SETTLE_FRAMES, default 2, meaning the frame starts counted before unmute (valid range 1..7).
REQ-004 The block SHALL have port VCLK  in  1  clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port nVRST_Tx  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port nVDSYNC  in  1  sync-nibble strobe; sync is valid on cycles where it is low.
REQ-007 The block SHALL have port nVSYNC_i  in  1  N64 vertical sync, active-low.
REQ-008 The block SHALL have port linemult_req  in  2  requested line multiplier: 00 = x1, 01 = x2, 10 = x3, 11 = treated as 01.
REQ-009 The block SHALL have port cfg_req  in  16  other PPU configuration word, applied only at frame start.
REQ-010 The block SHALL have port pll_locked  in  1  VCLK PLL lock status, needed for x3.
REQ-011 The block SHALL have port linemult_o  out  2  applied multiplier.
REQ-012 The block SHALL have port vclk_tx_sel  out  2  Tx clock select; always equal to linemult_o.
REQ-013 The block SHALL have port cfg_o  out  16  applied configuration.
REQ-014 The block SHALL have port mute_o  out  1  output blanking request.
REQ-015 The block SHALL have port lm_rst_n_o  out  1  active-low reset to the line multiplier.
REQ-016 The block SHALL have port busy_o  out  1  high whenever the state is not IDLE.
REQ-017 The block SHALL have port state_o  out  3  FSM state: IDLE = 0, WAIT_VS = 1, MUTE = 2, SWITCH = 3, SETTLE = 4.

Function
REQ-018 Frame start (vs_start) SHALL be a one-cycle pulse in the cycle where nVDSYNC is low and nVSYNC_i is 0, when the previous strobed sample was 1; cycles with nVDSYNC high SHALL be ignored.
REQ-019 The sanitized target SHALL be computed as follows: 11 maps to 01; 10 with pll_locked = 0 maps to 01; any other value passes unchanged.
REQ-020 In IDLE, if the target differs from linemult_o, the FSM SHALL go to WAIT_VS and latch the target.
REQ-021 In IDLE, at each vs_start, cfg_o SHALL load cfg_req with no mute.
REQ-022 In WAIT_VS, the latched target SHALL track the target every cycle.
REQ-023 In WAIT_VS, if the target equals linemult_o, the FSM SHALL return to IDLE.
REQ-024 In WAIT_VS, at vs_start, the FSM SHALL go to MUTE, and cfg_o SHALL load cfg_req in the same cycle.
REQ-025 MUTE: mute_o = 1 and lm_rst_n_o = 0 on entry (registered); the FSM SHALL stay exactly MUTE_CYCLES cycles, then go to SWITCH.
REQ-026 On the MUTE->SWITCH transition edge, linemult_o and vclk_tx_sel SHALL load the latched target.
REQ-027 SWITCH: the FSM SHALL stay CLKSW_CYCLES cycles, then go to SETTLE; lm_rst_n_o SHALL go to 1 on that transition.
REQ-028 SETTLE: mute_o SHALL remain 1; a 3-bit counter SHALL count vs_start pulses; at the SETTLE_FRAMES-th pulse, the FSM SHALL go to IDLE and mute_o SHALL go to 0 (registered).
REQ-029 Requests arriving in MUTE, SWITCH or SETTLE SHALL be ignored until IDLE, then evaluated per REQ-020 in the first IDLE cycle.
REQ-030 PLL-loss fallback: if linemult_o = 10 and pll_locked = 0 in any state other than MUTE or SWITCH, the FSM SHALL enter MUTE in the next cycle with target 01, without waiting for vs_start.
REQ-031 The fallback (REQ-030) SHALL take priority over all other IDLE, WAIT_VS and SETTLE transitions.
REQ-032 When a new latch (REQ-020) and a vs_start occur in the same IDLE cycle, cfg_o SHALL update and the FSM SHALL go to WAIT_VS; that vs_start SHALL NOT advance it to MUTE.
REQ-033 All outputs SHALL be registered; there SHALL be no combinational paths from inputs to outputs.

Reset
REQ-034 While nVRST_Tx is low: linemult_o = 00, vclk_tx_sel = 00, cfg_o = 0, mute_o = 1, lm_rst_n_o = 0, state = SWITCH, latched target = 00, counters = 0, and the previous strobed vsync sample = 1.
REQ-035 After reset release, the block SHALL run SWITCH, then SETTLE, then IDLE per REQ-027 and REQ-028, so the output stays muted for CLKSW_CYCLES cycles plus SETTLE_FRAMES frames.
REQ-036 Reset asserted mid-sequence SHALL abort immediately to the REQ-034 values.

Verification
REQ-037 Reset release with defaults and linemult_req = 00 -> state 3 for 16 cycles, then lm_rst_n_o rises; mute_o falls 1 cycle after the 2nd vs_start; busy_o = 0.
REQ-038 In IDLE at x1, set linemult_req = 01 -> WAIT_VS; at vs_start, MUTE for 4 cycles; linemult_o = vclk_tx_sel = 01 at cycle 5; lm_rst_n_o = 1 after 16 more cycles; unmute after 2 frames.
REQ-039 linemult_req = 10 with pll_locked = 0 -> linemult_o goes to 01, never 10; then raise pll_locked in IDLE -> sequence to 10.
REQ-040 At x3 in IDLE, drop pll_locked -> state = MUTE next cycle with no vs_start; linemult_o = 01 after 4 cycles.
REQ-041 Change linemult_req to 00 during SETTLE -> no effect until IDLE; then WAIT_VS with target 00; cfg_req changes are applied only at vs_start edges, including strobes with nVDSYNC high ignored.
REQ-042 Assert nVRST_Tx in SWITCH -> all outputs match REQ-034 in the same cycle (asynchronous).

Source files
------------

// File: rtl/ppu_linemult_seq.sv
// ppu_linemult_seq: switches the line multiplier frame-synchronously, with mute, clock-switch and settle phases
module ppu_linemult_seq #(
    parameter int MUTE_CYCLES   = 4,
    parameter int CLKSW_CYCLES  = 16,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic        VCLK,
    input  logic        nVRST_Tx,
    input  logic        nVDSYNC,
    input  logic        nVSYNC_i,
    input  logic [1:0]  linemult_req,
    input  logic [15:0] cfg_req,
    input  logic        pll_locked,
    output logic [1:0]  linemult_o,
    output logic [1:0]  vclk_tx_sel,
    output logic [15:0] cfg_o,
    output logic        mute_o,
    output logic        lm_rst_n_o,
    output logic        busy_o,
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        MUTE    = 3'd2,
        SWITCH  = 3'd3,
        SETTLE  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  tgt, tgt_q, tgt_nx, lm_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [2:0]  frm, frm_nx;
    logic [15:0] cfg_nx;
    logic        mute_nx, lm_rst_nx, vs_prev, vs_start, fallback;

    assign vs_start    = !nVDSYNC && !nVSYNC_i && vs_prev;
    assign tgt         = (linemult_req == 2'b11 || (linemult_req == 2'b10 && !pll_locked)) ? 2'b01 : linemult_req;
    assign fallback    = linemult_o == 2'b10 && !pll_locked && state != MUTE && state != SWITCH;
    assign vclk_tx_sel = linemult_o;
    assign state_o     = state;

    // next-state and next-output logic; PLL-loss fallback overrides every other transition
    always_comb begin
        state_nx  = state;
        tgt_nx    = tgt_q;
        lm_nx     = linemult_o;
        cnt_nx    = cnt;
        frm_nx    = frm;
        mute_nx   = mute_o;
        lm_rst_nx = lm_rst_n_o;
        cfg_nx    = (vs_start && (state == IDLE || state == WAIT_VS)) ? cfg_req : cfg_o;
        if (fallback) begin
            state_nx  = MUTE;
            tgt_nx    = 2'b01;
            cnt_nx    = '0;
            mute_nx   = 1'b1;
            lm_rst_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt != linemult_o) begin
                        state_nx = WAIT_VS;
                        tgt_nx   = tgt;
                    end
                end
                WAIT_VS: begin
                    tgt_nx = tgt;
                    if (tgt == linemult_o) begin
                        state_nx = IDLE;
                    end else if (vs_start) begin
                        state_nx  = MUTE;
                        cnt_nx    = '0;
                        mute_nx   = 1'b1;
                        lm_rst_nx = 1'b0;
                    end
                end
                MUTE: begin
                    if (cnt == 8'(MUTE_CYCLES - 1)) begin
                        state_nx = SWITCH;
                        cnt_nx   = '0;
                        lm_nx    = tgt_q;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                SWITCH: begin
                    if (cnt == 8'(CLKSW_CYCLES - 1)) begin
                        state_nx  = SETTLE;
                        cnt_nx    = '0;
                        frm_nx    = '0;
                        lm_rst_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (vs_start) begin
                        if (frm == 3'(SETTLE_FRAMES - 1)) begin
                            state_nx = IDLE;
                            frm_nx   = '0;
                            mute_nx  = 1'b0;
                        end else begin
                            frm_nx = frm + 3'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // state and registered outputs; reset lands in SWITCH so the block boots muted
    always_ff @(posedge VCLK or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            state      <= SWITCH;
            tgt_q      <= 2'b00;
            linemult_o <= 2'b00;
            cnt        <= '0;
            frm        <= '0;
            cfg_o      <= '0;
            mute_o     <= 1'b1;
            lm_rst_n_o <= 1'b0;
            busy_o     <= 1'b1;
        end else begin
            state      <= state_nx;
            tgt_q      <= tgt_nx;
            linemult_o <= lm_nx;
            cnt        <= cnt_nx;
            frm        <= frm_nx;
            cfg_o      <= cfg_nx;
            mute_o     <= mute_nx;
            lm_rst_n_o <= lm_rst_nx;
            busy_o     <= state_nx != IDLE;
        end
    end

    // previous strobed vsync sample; only cycles with the strobe low are sampled
    always_ff @(posedge VCLK or negedge nVRST_Tx) begin
        if (!nVRST_Tx) vs_prev <= 1'b1;
        else if (!nVDSYNC) vs_prev <= nVSYNC_i;
    end
endmodule
